// File: rtl/tile_map_engine_pkg.sv
// Shared types and constants for the tile map engine: tile IDs, FSM states,
// the default-map rule and the palette used by the tile images.
package tank_pkg;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_BRICK = 2'd1,
    TILE_STEEL = 2'd2,
    TILE_WATER = 2'd3
  } tile_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int COLOR_W_DEF = 12;

  // Default map: a steel frame around an empty field.
  localparam tile_e BORDER_TILE   = TILE_STEEL;
  localparam tile_e INTERIOR_TILE = TILE_EMPTY;
  // Anything outside the map (or asked for before the map exists) is solid.
  localparam tile_e OOB_TILE      = TILE_STEEL;

  // RGB444 palette for the tile images.
  localparam logic [11:0] CLR_BRICK    = 12'hC42;
  localparam logic [11:0] CLR_MORTAR   = 12'h888;
  localparam logic [11:0] CLR_STEEL    = 12'hAAA;
  localparam logic [11:0] CLR_STEEL_ED = 12'h666;
  localparam logic [11:0] CLR_RIVET    = 12'hFFF;
  localparam logic [11:0] CLR_WATER    = 12'h24F;
  localparam logic [11:0] CLR_RIPPLE   = 12'h6AF;

  function automatic tile_e default_tile(input int row, input int col,
                                         input int rows, input int cols);
    if (row == 0 || row == rows - 1 || col == 0 || col == cols - 1)
      return BORDER_TILE;
    return INTERIOR_TILE;
  endfunction

endpackage

// File: rtl/tile_map_engine_if.sv
// Tile-write and collision-query channels of the tile map engine.
//
// Write channel: a write happens on a rising clk edge where wr_valid and
// wr_ready are both 1. The master holds wr_col/wr_row/wr_tile stable while
// wr_valid is 1; wr_ready does not depend on wr_valid. Out-of-range
// coordinates are still accepted but leave the map untouched.
// Query channel: no backpressure. q_valid on an edge yields q_resp=1 with
// q_tile on the following cycle.
interface tile_map_if #(
  parameter int MAP_COLS = 20,
  parameter int MAP_ROWS = 15
);
  localparam int COL_W = $clog2(MAP_COLS);
  localparam int ROW_W = $clog2(MAP_ROWS);

  logic             wr_valid;
  logic             wr_ready;
  logic [COL_W-1:0] wr_col;
  logic [ROW_W-1:0] wr_row;
  logic [1:0]       wr_tile;

  logic             q_valid;
  logic [COL_W-1:0] q_col;
  logic [ROW_W-1:0] q_row;
  logic [1:0]       q_tile;
  logic             q_resp;

  modport master (
    output wr_valid, wr_col, wr_row, wr_tile, q_valid, q_col, q_row,
    input  wr_ready, q_tile, q_resp
  );

  modport slave (
    input  wr_valid, wr_col, wr_row, wr_tile, q_valid, q_col, q_row,
    output wr_ready, q_tile, q_resp
  );
endinterface

// File: rtl/tile_map_engine_tile_rom.sv
// Tile image ROM: one TILE x TILE image per tile ID, addressed by
// {tile_id, row offset, col offset}, registered (1-cycle) read.
module tile_rom
  import tank_pkg::*;
#(
  parameter int TILE_LOG2 = 5,
  parameter int COLOR_W   = COLOR_W_DEF
) (
  input  logic                     clk,
  input  logic [2*TILE_LOG2+1:0]   i_addr,
  output logic [COLOR_W-1:0]       o_color
);

  tile_e                w_tile;
  logic [TILE_LOG2-1:0] w_row;
  logic [TILE_LOG2-1:0] w_col;
  logic [2:0]           w_diag;
  logic [COLOR_W-1:0]   w_texel;
  logic [COLOR_W-1:0]   r_color;

  assign w_tile = tile_e'(i_addr[2*TILE_LOG2+1 -: 2]);
  assign w_row  = i_addr[2*TILE_LOG2-1 -: TILE_LOG2];
  assign w_col  = i_addr[TILE_LOG2-1:0];
  // Diagonal ripple phase for water: (row + col) mod 8.
  assign w_diag = w_row[2:0] + w_col[2:0];

  // Procedural images: brick courses with mortar, framed steel with a rivet,
  // water with diagonal ripples. Empty is black (and gated off downstream).
  always_comb begin
    w_texel = '0;
    case (w_tile)
      TILE_EMPTY: w_texel = '0;
      TILE_BRICK: begin
        if (w_row[2:0] == 3'd7 || w_col[3:0] == 4'hF) w_texel = COLOR_W'(CLR_MORTAR);
        else                                          w_texel = COLOR_W'(CLR_BRICK);
      end
      TILE_STEEL: begin
        if (w_row == '0 || w_col == '0)                    w_texel = COLOR_W'(CLR_STEEL_ED);
        else if (w_row[3:0] == 4'd1 && w_col[3:0] == 4'd1) w_texel = COLOR_W'(CLR_RIVET);
        else                                               w_texel = COLOR_W'(CLR_STEEL);
      end
      TILE_WATER: begin
        if (w_diag == 3'd0) w_texel = COLOR_W'(CLR_RIPPLE);
        else                w_texel = COLOR_W'(CLR_WATER);
      end
      default: w_texel = '0;
    endcase
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    r_color <= w_texel;
  end

  assign o_color = r_color;

endmodule

// File: rtl/tile_map_engine.sv
// Tile map engine: holds the playfield tile map, paints the background
// through a 2-stage pixel pipeline, accepts tile writes and answers
// collision queries. After reset an INIT sweep rebuilds the default map.
module tile_map_engine
  import tank_pkg::*;
#(
  parameter int TILE_LOG2 = 5,
  parameter int MAP_COLS  = 20,
  parameter int MAP_ROWS  = 15,
  parameter int COLOR_W   = COLOR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               video_on,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic               pixel_on,
  output logic [COLOR_W-1:0] color,
  output logic               busy,
  output state_e             o_dbg_state,
  tile_map_if.slave          bus
);

  localparam int CELLS    = MAP_COLS * MAP_ROWS;
  localparam int IDX_W    = $clog2(CELLS + 1);
  localparam int COL_W    = $clog2(MAP_COLS);
  localparam int ROW_W    = $clog2(MAP_ROWS);
  localparam int MAP_W_PX = MAP_COLS << TILE_LOG2;
  localparam int MAP_H_PX = MAP_ROWS << TILE_LOG2;
  localparam int TC_W     = 10 - TILE_LOG2;

  // Map storage, row-major, one 2-bit ID per cell.
  tile_e r_map [CELLS];

  state_e           r_state;
  state_e           w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             w_busy;
  logic             w_wr_ready;

  // ---------------- FSM ----------------
  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_next_state;
  end

  // Next state: leave INIT once the last cell has been written.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT: if (r_idx == IDX_W'(CELLS - 1)) w_next_state = ST_RUN;
      ST_RUN:  w_next_state = ST_RUN;
      default: w_next_state = ST_INIT;
    endcase
  end

  // FSM outputs; reset forces the INIT view even before the first edge.
  always_comb begin
    w_busy     = 1'b1;
    w_wr_ready = 1'b0;
    if (rst_n && r_state == ST_RUN) begin
      w_busy     = 1'b0;
      w_wr_ready = 1'b1;
    end
  end

  assign busy         = w_busy;
  assign bus.wr_ready = w_wr_ready;
  assign o_dbg_state  = r_state;

  // INIT cell walker: linear index plus row/col so the border test needs no divide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == ST_INIT) begin
      r_idx <= r_idx + 1'b1;
      if (r_col == COL_W'(MAP_COLS - 1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // ---------------- write channel ----------------
  logic             w_wr_fire;
  logic             w_wr_in_range;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_wr_fire     = bus.wr_valid && w_wr_ready;
  assign w_wr_in_range = (32'(bus.wr_col) < MAP_COLS) && (32'(bus.wr_row) < MAP_ROWS);
  assign w_wr_idx      = w_wr_in_range
                       ? IDX_W'(bus.wr_row) * IDX_W'(MAP_COLS) + IDX_W'(bus.wr_col)
                       : '0;

  // Map update: INIT sweep owns the port, otherwise accepted in-range writes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == ST_INIT)
        r_map[r_idx] <= default_tile(int'(r_row), int'(r_col), MAP_ROWS, MAP_COLS);
      else if (w_wr_fire && w_wr_in_range)
        r_map[w_wr_idx] <= tile_e'(bus.wr_tile);
    end
  end

  // ---------------- query channel ----------------
  logic             w_q_in_range;
  logic [IDX_W-1:0] w_q_idx;
  logic             r_q_resp;
  tile_e            r_q_tile;

  assign w_q_in_range = (32'(bus.q_col) < MAP_COLS) && (32'(bus.q_row) < MAP_ROWS);
  assign w_q_idx      = w_q_in_range
                      ? IDX_W'(bus.q_row) * IDX_W'(MAP_COLS) + IDX_W'(bus.q_col)
                      : '0;

  // Query response; reads the map before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q_resp <= 1'b0;
      r_q_tile <= TILE_EMPTY;
    end else begin
      r_q_resp <= bus.q_valid;
      if (bus.q_valid) begin
        if (r_state == ST_INIT || !w_q_in_range) r_q_tile <= OOB_TILE;
        else                                     r_q_tile <= r_map[w_q_idx];
      end
    end
  end

  assign bus.q_resp = r_q_resp;
  assign bus.q_tile = r_q_tile;

  // ---------------- pixel pipeline ----------------
  logic                 w_in_map;
  logic [TC_W-1:0]      w_tcol;
  logic [TC_W-1:0]      w_trow;
  logic [IDX_W-1:0]     w_pix_idx;
  logic                 r_s1_on;
  tile_e                r_s1_tile;
  logic [TILE_LOG2-1:0] r_s1_xoff;
  logic [TILE_LOG2-1:0] r_s1_yoff;
  logic                 r_s2_on;
  logic [COLOR_W-1:0]   w_rom_color;

  assign w_in_map  = (32'(x) < MAP_W_PX) && (32'(y) < MAP_H_PX);
  assign w_tcol    = x[9:TILE_LOG2];
  assign w_trow    = y[9:TILE_LOG2];
  assign w_pix_idx = w_in_map ? IDX_W'(w_trow) * IDX_W'(MAP_COLS) + IDX_W'(w_tcol) : '0;

  // Stage 1: map lookup plus in-tile offsets.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_on   <= 1'b0;
      r_s1_tile <= TILE_EMPTY;
      r_s1_xoff <= '0;
      r_s1_yoff <= '0;
    end else begin
      r_s1_on   <= video_on && w_in_map && (r_state == ST_RUN);
      r_s1_tile <= r_map[w_pix_idx];
      r_s1_xoff <= x[TILE_LOG2-1:0];
      r_s1_yoff <= y[TILE_LOG2-1:0];
    end
  end

  tile_rom #(
    .TILE_LOG2 (TILE_LOG2),
    .COLOR_W   (COLOR_W)
  ) u_tile_rom (
    .clk     (clk),
    .i_addr  ({r_s1_tile, r_s1_yoff, r_s1_xoff}),
    .o_color (w_rom_color)
  );

  // Stage 2: qualifier aligned with the registered ROM output.
  always_ff @(posedge clk) begin
    if (!rst_n) r_s2_on <= 1'b0;
    else        r_s2_on <= r_s1_on && (r_s1_tile != TILE_EMPTY);
  end

  assign pixel_on = r_s2_on;
  assign color    = r_s2_on ? w_rom_color : '0;

endmodule

// File: tb/tb_tile_map_engine.sv
// Directed testbench for tile_map_engine: reset/INIT timing, pixel colours,
// writes, queries, same-cycle hazards and reset mid-INIT.
module tb_tile_map_engine;
  import tank_pkg::*;

  localparam int TILE_LOG2 = 5;
  localparam int MAP_COLS  = 20;
  localparam int MAP_ROWS  = 15;
  localparam int COLOR_W   = 12;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               video_on = 1'b0;
  logic [9:0]         x = '0;
  logic [9:0]         y = '0;
  logic               pixel_on;
  logic [COLOR_W-1:0] color;
  logic               busy;
  state_e             dbg_state;

  tile_map_if #(.MAP_COLS(MAP_COLS), .MAP_ROWS(MAP_ROWS)) bus ();

  int checks = 0;
  int failures = 0;

  // Clock.
  always #5 clk = ~clk;

  tile_map_engine #(
    .TILE_LOG2 (TILE_LOG2),
    .MAP_COLS  (MAP_COLS),
    .MAP_ROWS  (MAP_ROWS),
    .COLOR_W   (COLOR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .video_on    (video_on),
    .x           (x),
    .y           (y),
    .pixel_on    (pixel_on),
    .color       (color),
    .busy        (busy),
    .o_dbg_state (dbg_state),
    .bus         (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a pixel and check the output 2 cycles later.
  task automatic pix(input string tag, input int px, input int py, input logic von,
                     input logic exp_on, input logic [11:0] exp_c);
    x = 10'(px); y = 10'(py); video_on = von;
    step();
    step();
    check({tag, ".on"}, 32'(pixel_on), 32'(exp_on));
    check({tag, ".color"}, 32'(color), 32'(exp_c));
  endtask

  task automatic query(input string tag, input int c, input int r, input logic [1:0] exp_t);
    bus.q_valid = 1'b1; bus.q_col = 5'(c); bus.q_row = 4'(r);
    step();
    bus.q_valid = 1'b0;
    check({tag, ".resp"}, 32'(bus.q_resp), 32'd1);
    check({tag, ".tile"}, 32'(bus.q_tile), 32'(exp_t));
  endtask

  task automatic write(input string tag, input int c, input int r, input logic [1:0] t);
    bus.wr_valid = 1'b1; bus.wr_col = 5'(c); bus.wr_row = 4'(r); bus.wr_tile = t;
    check({tag, ".ready"}, 32'(bus.wr_ready), 32'd1);
    step();
    bus.wr_valid = 1'b0;
  endtask

  // Wait for INIT to finish; rst_n must have just been released.
  task automatic init_wait(input string tag);
    int  cnt;
    logic seen_rdy;
    logic seen_pix;
    cnt = 0; seen_rdy = 1'b0; seen_pix = 1'b0;
    while (busy === 1'b1 && cnt < 400) begin
      step();
      cnt++;
      if (busy === 1'b1) begin
        if (bus.wr_ready !== 1'b0) seen_rdy = 1'b1;
        if (pixel_on !== 1'b0)     seen_pix = 1'b1;
      end
    end
    check({tag, ".busy_cycles"}, 32'(cnt), 32'd300);
    check({tag, ".ready_low"}, 32'(seen_rdy), 32'd0);
    check({tag, ".pix_low"}, 32'(seen_pix), 32'd0);
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    check({tag, ".ready_end"}, 32'(bus.wr_ready), 32'd1);
    check({tag, ".state_end"}, 32'(dbg_state), 32'(ST_RUN));
  endtask

  initial begin
    bus.wr_valid = 1'b0; bus.wr_col = '0; bus.wr_row = '0; bus.wr_tile = '0;
    bus.q_valid  = 1'b0; bus.q_col  = '0; bus.q_row  = '0;

    // Reset values.
    video_on = 1'b1; x = 10'd10; y = 10'd10;
    step(); step(); step();
    check("rst.state", 32'(dbg_state), 32'(ST_INIT));
    check("rst.busy", 32'(busy), 32'd1);
    check("rst.ready", 32'(bus.wr_ready), 32'd0);
    check("rst.pix", 32'(pixel_on), 32'd0);
    check("rst.color", 32'(color), 32'd0);
    check("rst.qresp", 32'(bus.q_resp), 32'd0);
    check("rst.qtile", 32'(bus.q_tile), 32'd0);

    rst_n = 1'b1;
    init_wait("init1");

    // Steel border pixels.
    pix("steel_10_10", 10, 10, 1'b1, 1'b1, 12'hAAA);
    pix("steel_edge", 0, 0, 1'b1, 1'b1, 12'h666);
    pix("steel_rivet", 17, 17, 1'b1, 1'b1, 12'hFFF);
    pix("empty_100", 100, 100, 1'b1, 1'b0, 12'h000);

    // One pixel per cycle, back to back.
    x = 10'd10;  y = 10'd10;  step();
    x = 10'd100; y = 10'd100; step();
    check("pipe0.color", 32'(color), 32'hAAA);
    x = 10'd0;   y = 10'd0;   step();
    check("pipe1.on", 32'(pixel_on), 32'd0);
    step();
    check("pipe2.color", 32'(color), 32'h666);

    // Queries.
    query("q_0_5", 0, 5, 2'd2);
    step();
    check("q_0_5.resp_drop", 32'(bus.q_resp), 32'd0);
    query("q_oob", 20, 3, 2'd2);

    // Same-cycle write and query to (3,3): old ID returned.
    bus.wr_valid = 1'b1; bus.wr_col = 5'd3; bus.wr_row = 4'd3; bus.wr_tile = 2'd1;
    bus.q_valid  = 1'b1; bus.q_col  = 5'd3; bus.q_row  = 4'd3;
    step();
    bus.wr_valid = 1'b0; bus.q_valid = 1'b0;
    check("wq_same.resp", 32'(bus.q_resp), 32'd1);
    check("wq_same.tile", 32'(bus.q_tile), 32'd0);
    query("wq_requery", 3, 3, 2'd1);

    // Brick pixels and out-of-map.
    pix("brick_100", 100, 100, 1'b1, 1'b1, 12'hC42);
    pix("brick_mortar", 110, 103, 1'b1, 1'b1, 12'h888);
    pix("out_700", 700, 100, 1'b1, 1'b0, 12'h000);
    pix("out_y500", 100, 500, 1'b1, 1'b0, 12'h000);

    // Pixel read in the same cycle as a write to its cell sees the old ID.
    bus.wr_valid = 1'b1; bus.wr_col = 5'd5; bus.wr_row = 4'd5; bus.wr_tile = 2'd3;
    x = 10'd170; y = 10'd170; video_on = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    step();
    check("wp_same.on", 32'(pixel_on), 32'd0);
    pix("water_170", 170, 170, 1'b1, 1'b1, 12'h24F);
    pix("water_ripple", 160, 160, 1'b1, 1'b1, 12'h6AF);

    // Out-of-range write is accepted and dropped.
    write("wr_oob", 20, 3, 2'd3);
    query("wr_oob.cell_0_4", 0, 4, 2'd2);
    query("wr_oob.cell_19_3", 19, 3, 2'd2);
    query("wr_oob.cell_1_4", 1, 4, 2'd0);

    // video_on low blanks the output.
    pix("video_off", 10, 10, 1'b0, 1'b0, 12'h000);

    // Reset from RUN.
    video_on = 1'b1; x = 10'd10; y = 10'd10;
    rst_n = 1'b0;
    step(); step();
    check("rst2.state", 32'(dbg_state), 32'(ST_INIT));
    check("rst2.pix", 32'(pixel_on), 32'd0);
    check("rst2.color", 32'(color), 32'd0);
    check("rst2.ready", 32'(bus.wr_ready), 32'd0);
    check("rst2.qtile", 32'(bus.q_tile), 32'd0);

    // Release, query during INIT, then reset again at cell 150.
    rst_n = 1'b1;
    query("q_init", 3, 3, 2'd2);
    for (int i = 0; i < 149; i++) step();
    check("mid_init.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    init_wait("init2");

    // Map rebuilt from scratch.
    query("after.cell_3_3", 3, 3, 2'd0);
    query("after.cell_5_5", 5, 5, 2'd0);
    query("after.cell_0_0", 0, 0, 2'd2);
    pix("after.pix_100", 100, 100, 1'b1, 1'b0, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_map_engine.md
TILE_MAP_ENGINE -- requirements
Module: tile_map_engine

Interface
REQ-001 SHALL have parameter TILE_LOG2, default 5, log2 of tile edge in pixels (32 px tiles).
REQ-002 SHALL have parameter MAP_COLS, default 20, tile columns in map.
REQ-003 SHALL have parameter MAP_ROWS, default 15, tile rows in map.
REQ-004 SHALL have parameter COLOR_W, default 12, RGB444 pixel width.
REQ-005 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-007 SHALL have port video_on  in  1  active-video qualifier.
REQ-008 SHALL have port x, y  in  10 each  current scan pixel coordinate.
REQ-009 SHALL have port pixel_on  out  1  background pixel valid, pipelined.
REQ-010 SHALL have port color  out  COLOR_W  background pixel color, pipelined.
REQ-011 SHALL have port busy  out  1  map initialisation in progress.
REQ-012 SHALL have ports wr_valid (in, 1), wr_ready (out, 1), wr_col (in, clog2(MAP_COLS)), wr_row (in, clog2(MAP_ROWS)) and wr_tile (in, 2), forming the tile-write channel.
REQ-013 SHALL have ports q_valid (in, 1), q_col (in), q_row (in), q_tile (out, 2) and q_resp (out, 1), forming the collision-query channel.

Function
REQ-014 Tile IDs SHALL be 0 EMPTY, 1 BRICK, 2 STEEL and 3 WATER.
REQ-015 Map storage SHALL be a MAP_COLS x MAP_ROWS register array of 2-bit IDs with read-before-write semantics.
REQ-016 FSM states SHALL be INIT and RUN; INIT SHALL step a cell index 0..MAP_COLS*MAP_ROWS-1, one cell per cycle, row-major.
REQ-017 INIT SHALL write STEEL to border cells (row 0, last row, col 0, last col) and EMPTY to all other cells, then go to RUN on the cycle after the last cell.
REQ-018 busy SHALL be 1 exactly while in INIT; wr_ready SHALL be 0 in INIT and 1 in RUN.
REQ-019 A write SHALL occur when wr_valid && wr_ready; an out-of-range wr_col/wr_row SHALL be accepted and dropped, with no change to the map.
REQ-020 Pixel path SHALL be two stages: stage 1 registers tile ID plus in-tile offsets x[TILE_LOG2-1:0] and y[TILE_LOG2-1:0]; stage 2 registers the tile_rom output.
REQ-021 The total pixel latency from x/y/video_on to color/pixel_on SHALL be 2 cycles, fully pipelined, accepting one pixel per cycle.
REQ-022 pixel_on SHALL equal video_on delayed 2 cycles AND in-map AND tile ID != EMPTY AND state == RUN.
REQ-023 In-map SHALL mean x < MAP_COLS<<TILE_LOG2 and y < MAP_ROWS<<TILE_LOG2.
REQ-024 color SHALL be 0 whenever pixel_on is 0.
REQ-025 A query SHALL set q_resp=1 for exactly one cycle after q_valid, with q_tile = the cell ID; an out-of-range query SHALL return STEEL.
REQ-026 A query and a write to the same cell in the same cycle SHALL return the old ID.
REQ-027 A pixel read in the same cycle as a write to its cell SHALL see the old ID; the new ID SHALL be visible from the next cycle.
REQ-028 A query during INIT SHALL return q_resp=1 with q_tile=STEEL.

Reset
REQ-029 While rst_n=0 the block SHALL be in state INIT with cell index 0, and pixel_on=0, color=0, q_resp=0, q_tile=0, busy=1, wr_ready=0 and all pipeline valids cleared.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL restart INIT from cell 0, with no partial state retained.

Structure
REQ-031 Package tank_pkg SHALL hold the tile-ID enum, the COLOR_W default and the default-map rule constants.
REQ-032 Sub-module tile_rom SHALL implement a synchronous 1-cycle read indexed by {tile_id, row offset, col offset}, producing COLOR_W data, with one image per tile ID.

Verification
REQ-033 Reset release -> busy=1 for exactly 300 cycles, wr_ready=0 and pixel_on=0 throughout, then busy=0 and wr_ready=1.
REQ-034 RUN, video_on=1, x=10, y=10 -> 2 cycles later pixel_on=1 and color=STEEL rom[10][10]; x=100, y=100 -> pixel_on=0 and color=0.
REQ-035 Write (col 3, row 3, BRICK), then x=100, y=100 -> pixel_on=1 with color=BRICK rom[4][4]; x=700, y=100 -> pixel_on=0 (out of map).
REQ-036 Query (0, 5) -> next cycle q_resp=1 and q_tile=2; write BRICK and query (3,3) in the same cycle -> q_tile=0, and a re-query returns 1.
REQ-037 Write with wr_col=20 -> accepted, map unchanged; video_on=0 -> pixel_on=0 and color=0 after 2 cycles.
REQ-038 rst_n pulsed low at INIT cell 150 -> busy stays high for a fresh 300 cycles; a prior BRICK at (3,3) is cleared to EMPTY.
